regfile_wb_arbiter: RTL and testbench

- Writeback arbiter and scoreboard for the 16x16 register file.
- Shares the single general write port (WA1/WD1/RegWrite) among three producers: ALU, load unit and the multi-cycle mul/div unit (MDU). Drives the dedicated R0 write port (R0W/R0D) with the MDU high word.
- Keeps a per-register pending bit so decode can stall on RAW hazards against writes that are still in flight.

---
 rtl/regfile_wb_arbiter_pkg.sv | 16 +
 rtl/regfile_wb_arbiter_rr_arb3.sv | 49 ++++
 rtl/regfile_wb_arbiter.sv | 107 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter and scoreboard.
package regfile_wb_arbiter_pkg;

    localparam int DW   = 16;
    localparam int AW   = 4;
    localparam int NREG = 1 << AW;

    // Round-robin pointer and requester indices.
    localparam int PW = 2;
    typedef logic [PW-1:0] ptr_t;

    localparam ptr_t REQ_ALU = 2'd0;
    localparam ptr_t REQ_LD  = 2'd1;
    localparam ptr_t REQ_MDU = 2'd2;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb3.sv
// Three-way round-robin arbiter. The grant is combinational from req and the
// pointer; the pointer advances past the winner on every grant.
module rr_arb3
    import regfile_wb_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    output logic [2:0] gnt
);

    ptr_t ptr;

    // Priority search starting at the pointer, wrapping A -> M -> D -> A.
    always_comb begin
        gnt = 3'b000;
        case (ptr)
            REQ_LD: begin
                if      (req[1]) gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
            end
            REQ_MDU: begin
                if      (req[2]) gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
            end
            default: begin
                if      (req[0]) gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
            end
        endcase
    end

    // Pointer moves to the requester after the winner; holds with no grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= REQ_ALU;
        end else if (gnt[0]) begin
            ptr <= REQ_LD;
        end else if (gnt[1]) begin
            ptr <= REQ_MDU;
        end else if (gnt[2]) begin
            ptr <= REQ_ALU;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the 16x16 register file: shares the general write
// port between ALU, load unit and MDU, drives the R0 port with the MDU high
// word, and tracks in-flight destinations for RAW stall detection.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            a_valid,
    input  logic [AW-1:0]   a_addr,
    input  logic [DW-1:0]   a_data,
    output logic            a_ready,
    input  logic            m_valid,
    input  logic [AW-1:0]   m_addr,
    input  logic [DW-1:0]   m_data,
    output logic            m_ready,
    input  logic            d_valid,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_lo,
    input  logic [DW-1:0]   d_hi,
    output logic            d_ready,
    output logic            rf_we,
    output logic [AW-1:0]   rf_wa,
    output logic [DW-1:0]   rf_wd,
    output logic            rf_r0w,
    output logic [DW-1:0]   rf_r0d,
    input  logic            sb_set,
    input  logic [AW-1:0]   sb_addr,
    input  logic            sb_r0,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic            stall,
    output logic [NREG-1:0] pending
);

    logic [2:0]      req;
    logic [2:0]      gnt;
    logic [AW-1:0]   win_addr;
    logic [DW-1:0]   win_data;
    logic            wr_en;
    logic [NREG-1:0] clr_mask;
    logic [NREG-1:0] set_mask;

    // No grants while reset is asserted, so nothing is accepted and lost.
    assign req = {d_valid, m_valid, a_valid} & {3{~rst}};

    rr_arb3 u_arb (
        .clk (clk),
        .rst (rst),
        .req (req),
        .gnt (gnt)
    );

    assign a_ready = gnt[REQ_ALU];
    assign m_ready = gnt[REQ_LD];
    assign d_ready = gnt[REQ_MDU];

    // Select the winning address/data; R0 on the general port is dropped.
    always_comb begin
        win_addr = a_addr;
        win_data = a_data;
        if (gnt[REQ_LD]) begin
            win_addr = m_addr;
            win_data = m_data;
        end else if (gnt[REQ_MDU]) begin
            win_addr = d_addr;
            win_data = d_lo;
        end
        wr_en = (|gnt) && (win_addr != '0);
    end

    // Scoreboard masks: clears come from the write being registered now.
    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (wr_en)        clr_mask[win_addr] = 1'b1;
        if (gnt[REQ_MDU]) clr_mask[0]        = 1'b1;
        if (sb_set) begin
            if (sb_addr != '0) set_mask[sb_addr] = 1'b1;
            if (sb_r0)         set_mask[0]       = 1'b1;
        end
    end

    // Registered write-port outputs; set beats clear for the newer owner.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we   <= 1'b0;
            rf_wa   <= '0;
            rf_wd   <= '0;
            rf_r0w  <= 1'b0;
            rf_r0d  <= '0;
            pending <= '0;
        end else begin
            rf_we  <= wr_en;
            rf_r0w <= gnt[REQ_MDU];
            if (wr_en) begin
                rf_wa <= win_addr;
                rf_wd <= win_data;
            end
            if (gnt[REQ_MDU]) rf_r0d <= d_hi;
            pending <= (pending & ~clr_mask) | set_mask;
        end
    end

    assign stall = pending[rs1] | pending[rs2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for the writeback arbiter and scoreboard.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, m_valid, d_valid;
    logic [3:0]  a_addr, m_addr, d_addr;
    logic [15:0] a_data, m_data, d_lo, d_hi;
    logic        a_ready, m_ready, d_ready;
    logic        rf_we, rf_r0w;
    logic [3:0]  rf_wa;
    logic [15:0] rf_wd, rf_r0d;
    logic        sb_set, sb_r0;
    logic [3:0]  sb_addr, rs1, rs2;
    logic        stall;
    logic [15:0] pending;

    int checks   = 0;
    int failures = 0;

    regfile_wb_arbiter dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .m_valid(m_valid), .m_addr(m_addr), .m_data(m_data), .m_ready(m_ready),
        .d_valid(d_valid), .d_addr(d_addr), .d_lo(d_lo), .d_hi(d_hi), .d_ready(d_ready),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .rf_r0w(rf_r0w), .rf_r0d(rf_r0d),
        .sb_set(sb_set), .sb_addr(sb_addr), .sb_r0(sb_r0),
        .rs1(rs1), .rs2(rs2), .stall(stall), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_valid = 0; m_valid = 0; d_valid = 0;
        a_addr = 0; m_addr = 0; d_addr = 0;
        a_data = 0; m_data = 0; d_lo = 0; d_hi = 0;
        sb_set = 0; sb_addr = 0; sb_r0 = 0;
        rs1 = 0; rs2 = 0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        a_valid = 1; m_valid = 1; d_valid = 1;
        a_addr = 1; a_data = 16'hA001; m_addr = 2; d_addr = 3;
        rst = 1;
        tick();
        checks++;
        if ({d_ready, m_ready, a_ready} !== 3'b000) begin
            failures++;
            $display("FAIL reset_ready1 got=%b exp=000", {d_ready, m_ready, a_ready});
        end
        tick();
        checks++;
        if ({d_ready, m_ready, a_ready} !== 3'b000) begin
            failures++;
            $display("FAIL reset_ready2 got=%b exp=000", {d_ready, m_ready, a_ready});
        end
        checks++;
        if (rf_we !== 1'b0 || rf_r0w !== 1'b0 || pending !== 16'h0000) begin
            failures++;
            $display("FAIL reset_state got we=%b r0w=%b pend=%h exp 0 0 0000", rf_we, rf_r0w, pending);
        end
        rst = 0;
        #1;
        checks++;
        if ({d_ready, m_ready, a_ready} !== 3'b001) begin
            failures++;
            $display("FAIL reset_first_grant got=%b exp=001", {d_ready, m_ready, a_ready});
        end
        tick();
        idle_inputs();
        checks++;
        if (rf_we !== 1'b1 || rf_wa !== 4'd1 || rf_wd !== 16'hA001) begin
            failures++;
            $display("FAIL reset_first_write got we=%b wa=%0d wd=%h exp 1 1 a001", rf_we, rf_wa, rf_wd);
        end
    endtask

    task automatic test_single_alu();
        reset_dut();
        a_valid = 1; a_addr = 5; a_data = 16'h1234;
        #1;
        checks++;
        if ({d_ready, m_ready, a_ready} !== 3'b001) begin
            failures++;
            $display("FAIL alu_ready got=%b exp=001", {d_ready, m_ready, a_ready});
        end
        tick();
        a_valid = 0;
        checks++;
        if (rf_we !== 1'b1 || rf_wa !== 4'd5 || rf_wd !== 16'h1234 || rf_r0w !== 1'b0) begin
            failures++;
            $display("FAIL alu_write got we=%b wa=%0d wd=%h r0w=%b exp 1 5 1234 0", rf_we, rf_wa, rf_wd, rf_r0w);
        end
        tick();
        checks++;
        if (rf_we !== 1'b0 || rf_wa !== 4'd5 || rf_wd !== 16'h1234) begin
            failures++;
            $display("FAIL alu_after got we=%b wa=%0d wd=%h exp 0 5 1234", rf_we, rf_wa, rf_wd);
        end
    endtask

    task automatic test_contention();
        int          exp_seq [6] = '{0, 1, 2, 0, 1, 2};
        logic [3:0]  exp_wa  [3] = '{4'd1, 4'd2, 4'd13};
        logic [15:0] exp_wd  [3] = '{16'h1111, 16'h2222, 16'h0002};
        logic [2:0]  exp_g;
        reset_dut();
        a_valid = 1; a_addr = 1;  a_data = 16'h1111;
        m_valid = 1; m_addr = 2;  m_data = 16'h2222;
        d_valid = 1; d_addr = 13; d_lo = 16'h0002; d_hi = 16'hFFFF;
        for (int i = 0; i < 6; i++) begin
            #1;
            exp_g = 3'b001 << exp_seq[i];
            checks++;
            if ({d_ready, m_ready, a_ready} !== exp_g) begin
                failures++;
                $display("FAIL contention_grant[%0d] got=%b exp=%b", i, {d_ready, m_ready, a_ready}, exp_g);
            end
            tick();
            checks++;
            if (rf_we !== 1'b1 || rf_wa !== exp_wa[exp_seq[i]] || rf_wd !== exp_wd[exp_seq[i]] ||
                rf_r0w !== (exp_seq[i] == 2)) begin
                failures++;
                $display("FAIL contention_write[%0d] got we=%b wa=%0d wd=%h r0w=%b exp 1 %0d %h %b", i,
                         rf_we, rf_wa, rf_wd, rf_r0w, exp_wa[exp_seq[i]], exp_wd[exp_seq[i]], exp_seq[i] == 2);
            end
            if (exp_seq[i] == 2) begin
                checks++;
                if (rf_r0d !== 16'hFFFF) begin
                    failures++;
                    $display("FAIL contention_r0d[%0d] got=%h exp=ffff", i, rf_r0d);
                end
            end
        end
        idle_inputs();
        tick();
        checks++;
        if (rf_we !== 1'b0 || rf_r0w !== 1'b0) begin
            failures++;
            $display("FAIL contention_idle got we=%b r0w=%b exp 0 0", rf_we, rf_r0w);
        end
    endtask

    task automatic test_hazard();
        reset_dut();
        sb_set = 1; sb_addr = 3;
        tick();
        sb_set = 0; rs1 = 3; rs2 = 7;
        #1;
        checks++;
        if (pending !== 16'h0008 || stall !== 1'b1) begin
            failures++;
            $display("FAIL hazard_set got pend=%h stall=%b exp 0008 1", pending, stall);
        end
        rs1 = 7; rs2 = 3;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL hazard_rs2 got=%b exp=1", stall);
        end
        rs1 = 3; rs2 = 7;
        m_valid = 1; m_addr = 3; m_data = 16'hBEEF;
        #1;
        checks++;
        if (m_ready !== 1'b1 || stall !== 1'b1) begin
            failures++;
            $display("FAIL hazard_grant got m_ready=%b stall=%b exp 1 1", m_ready, stall);
        end
        tick();
        m_valid = 0;
        checks++;
        if (rf_we !== 1'b1 || rf_wa !== 4'd3 || rf_wd !== 16'hBEEF || pending !== 16'h0000 || stall !== 1'b0) begin
            failures++;
            $display("FAIL hazard_clear got we=%b wa=%0d wd=%h pend=%h stall=%b exp 1 3 beef 0000 0",
                     rf_we, rf_wa, rf_wd, pending, stall);
        end
    endtask

    task automatic test_collision();
        reset_dut();
        sb_set = 1; sb_addr = 3;
        tick();
        a_valid = 1; a_addr = 3; a_data = 16'h0C0C;
        tick();
        a_valid = 0; sb_set = 0;
        checks++;
        if (rf_we !== 1'b1 || rf_wa !== 4'd3 || pending !== 16'h0008) begin
            failures++;
            $display("FAIL collision got we=%b wa=%0d pend=%h exp 1 3 0008", rf_we, rf_wa, pending);
        end
        sb_set = 1; sb_addr = 9; sb_r0 = 1;
        tick();
        sb_set = 0; sb_r0 = 0;
        checks++;
        if (pending !== 16'h0209) begin
            failures++;
            $display("FAIL r0_set got pend=%h exp=0209", pending);
        end
        d_valid = 1; d_addr = 9; d_lo = 16'h0009; d_hi = 16'h00A5;
        tick();
        d_valid = 0;
        checks++;
        if (rf_r0w !== 1'b1 || rf_r0d !== 16'h00A5 || rf_wa !== 4'd9 || pending !== 16'h0008) begin
            failures++;
            $display("FAIL r0_clear got r0w=%b r0d=%h wa=%0d pend=%h exp 1 00a5 9 0008", rf_r0w, rf_r0d, rf_wa, pending);
        end
    endtask

    task automatic test_addr0_reset();
        reset_dut();
        a_valid = 1; a_addr = 0; a_data = 16'h5555;
        #1;
        checks++;
        if (a_ready !== 1'b1) begin
            failures++;
            $display("FAIL addr0_ready got=%b exp=1", a_ready);
        end
        tick();
        a_valid = 0;
        checks++;
        if (rf_we !== 1'b0 || rf_r0w !== 1'b0 || pending !== 16'h0000) begin
            failures++;
            $display("FAIL addr0_write got we=%b r0w=%b pend=%h exp 0 0 0000", rf_we, rf_r0w, pending);
        end
        sb_set = 1; sb_addr = 6;
        tick();
        sb_set = 0;
        d_valid = 1; d_addr = 4; d_lo = 16'h0007; d_hi = 16'h0008;
        tick();
        d_valid = 0;
        checks++;
        if (rf_we !== 1'b1 || rf_r0w !== 1'b1 || pending !== 16'h0040) begin
            failures++;
            $display("FAIL midop_grant got we=%b r0w=%b pend=%h exp 1 1 0040", rf_we, rf_r0w, pending);
        end
        rst = 1; a_valid = 1; a_addr = 2;
        #1;
        checks++;
        if (a_ready !== 1'b0) begin
            failures++;
            $display("FAIL midop_ready got=%b exp=0", a_ready);
        end
        tick();
        rst = 0; a_valid = 0;
        checks++;
        if (rf_we !== 1'b0 || rf_r0w !== 1'b0 || pending !== 16'h0000 || rf_wa !== 4'd0) begin
            failures++;
            $display("FAIL midop_reset got we=%b r0w=%b pend=%h wa=%0d exp 0 0 0000 0", rf_we, rf_r0w, pending, rf_wa);
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        test_reset();
        test_single_alu();
        test_contention();
        test_hazard();
        test_collision();
        test_addr0_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
